// File: rtl/mstr0_pkg.sv
// Shared types and helpers for the mstr0 burst writer: FSM state encoding,
// command length width and the burst length clamp.
package mstr0_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        DATA,
        RESP,
        FIN
    } state_e;

    localparam int unsigned DEF_DW         = 32;
    localparam int unsigned BYTES_PER_BEAT = DEF_DW / 8;
    localparam int unsigned LEN_W          = 5;

    function automatic logic [LEN_W-1:0] min_len(
        input logic [31:0] remain,
        input logic [31:0] max
    );
        return (remain < max) ? LEN_W'(remain) : LEN_W'(max);
    endfunction

endpackage

// File: rtl/mstr0_beat_ctr.sv
// Beat counter for one burst: latches the burst length when the command
// is accepted, counts transferred beats and flags the final beat.
module mstr0_beat_ctr
    import mstr0_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             inc_i,
    input  logic [LEN_W-1:0] len_i,
    output logic [LEN_W-1:0] len_o,
    output logic             last_o
);

    logic [LEN_W-1:0] beat_q;
    logic [LEN_W-1:0] len_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q <= '0;
            len_q  <= '0;
        end else if (load_i) begin
            beat_q <= '0;
            len_q  <= len_i;
        end else if (inc_i) begin
            beat_q <= beat_q + LEN_W'(1);
        end
    end

    assign len_o  = len_q;
    assign last_o = (beat_q == (len_q - LEN_W'(1)));

endmodule

// File: rtl/mstr0_burst_writer.sv
// Drains the pixel FIFO's FWFT read port and writes the words to memory as
// bursts of at most BURST_MAX beats over a cmd/write/response master port.
module mstr0_burst_writer
    import mstr0_pkg::*;
#(
    parameter int unsigned DW        = DEF_DW,
    parameter int unsigned AW        = 32,
    parameter int unsigned CW        = 16,
    parameter int unsigned BURST_MAX = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AW-1:0]    base_addr,
    input  logic [CW-1:0]    total_words,
    output logic             busy,
    output logic             done,
    output logic             err,
    input  logic [DW-1:0]    fifo_data_out,
    input  logic             fifo_empty,
    output logic             mstr0_ready,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [AW-1:0]    cmd_addr,
    output logic [LEN_W-1:0] cmd_len,
    output logic             wvalid,
    input  logic             wready,
    output logic [DW-1:0]    wdata,
    output logic             wlast,
    input  logic             bvalid,
    input  logic             berr,
    output logic             bready
);

    localparam int unsigned STEP = BYTES_PER_BEAT * DW / DEF_DW;

    state_e           state_q;
    logic [AW-1:0]    addr_q;
    logic [CW-1:0]    remain_q;
    logic             err_q;
    logic             done_q;

    logic             in_data;
    logic             xfer;
    logic             cmd_hs;
    logic             beat_last;
    logic [LEN_W-1:0] len_q;

    assign in_data = (state_q == DATA);
    assign xfer    = wvalid & wready;
    assign cmd_hs  = cmd_valid & cmd_ready;

    mstr0_beat_ctr u_beat_ctr (
        .clk    (clk),
        .rst    (rst),
        .load_i (cmd_hs),
        .inc_i  (xfer),
        .len_i  (cmd_len),
        .len_o  (len_q),
        .last_o (beat_last)
    );

    // Command fields come straight from the job registers, which only move in
    // DATA, so they stay stable for the whole CMD wait.
    assign cmd_valid   = (state_q == CMD);
    assign cmd_addr    = addr_q;
    assign cmd_len     = min_len(32'(remain_q), 32'(BURST_MAX));

    assign wvalid      = in_data & ~fifo_empty;
    assign wdata       = fifo_data_out;
    assign wlast       = beat_last & wvalid;
    assign mstr0_ready = in_data & wready;
    assign bready      = (state_q == RESP);

    assign busy        = (state_q == CMD) || (state_q == DATA) || (state_q == RESP);
    assign done        = done_q;
    assign err         = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= (state_q == FIN);
            case (state_q)
                IDLE: begin
                    if (start) begin
                        err_q <= 1'b0;
                        if (total_words != '0) begin
                            addr_q   <= base_addr;
                            remain_q <= total_words;
                            state_q  <= CMD;
                        end else begin
                            state_q  <= FIN;
                        end
                    end
                end
                CMD: begin
                    if (cmd_ready) begin
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        if (remain_q != '0) begin
                            remain_q <= remain_q - CW'(1);
                        end
                        if (beat_last) begin
                            addr_q  <= addr_q + AW'(len_q) * AW'(STEP);
                            state_q <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (bvalid) begin
                        if (berr) begin
                            err_q <= 1'b1;
                        end
                        state_q <= (remain_q == '0) ? FIN : CMD;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mstr0_burst_writer.sv
// Scoreboard bench for mstr0_burst_writer: a queue-based FIFO and memory slave
// with random backpressure, expected bursts derived from the job parameters.
module tb_mstr0_burst_writer;

    typedef struct packed {
        logic [31:0] addr;
        logic [4:0]  len;
    } cmd_t;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] total_words = '0;
    logic        busy, done, err;
    logic [31:0] fifo_data_out = '0;
    logic        fifo_empty = 1'b1;
    logic        mstr0_ready;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [31:0] cmd_addr;
    logic [4:0]  cmd_len;
    logic        wvalid;
    logic        wready = 1'b0;
    logic [31:0] wdata;
    logic        wlast;
    logic        bvalid = 1'b0;
    logic        berr = 1'b0;
    logic        bready;

    mstr0_burst_writer #(
        .DW        (32),
        .AW        (32),
        .CW        (16),
        .BURST_MAX (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .base_addr     (base_addr),
        .total_words   (total_words),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .fifo_data_out (fifo_data_out),
        .fifo_empty    (fifo_empty),
        .mstr0_ready   (mstr0_ready),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_addr      (cmd_addr),
        .cmd_len       (cmd_len),
        .wvalid        (wvalid),
        .wready        (wready),
        .wdata         (wdata),
        .wlast         (wlast),
        .bvalid        (bvalid),
        .berr          (berr),
        .bready        (bready)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    cmd_t        exp_cmd_q[$];
    beat_t       exp_beat_q[$];
    logic        exp_done_q[$];

    logic [31:0] fifo_q[$];
    logic [31:0] src_q[$];

    int unsigned cmd_pct = 100, w_pct = 100, b_pct = 100, prod_gap = 0;
    logic [7:0]  berr_plan = '0;
    int unsigned resp_idx = 0;
    int          resp_pend = 0;
    int unsigned cyc = 0, pop_cnt = 0;
    bit          pend_clear = 0, pend_pop = 0, pend_b = 0, pend_wlast = 0;

    int unsigned mon_cyc = 0, start_cyc = 0, done_cyc = 0;
    int unsigned done_cnt = 0, beat_cnt = 0, cmdv_cnt = 0;
    bit          prev_stall = 0, pend_berr = 0;
    logic [31:0] prev_addr = '0;
    logic [4:0]  prev_len = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // FIFO and memory-slave model: inputs change on the falling edge, the
    // handshakes of the upcoming rising edge are sampled 1 ns later.
    always begin
        @(negedge clk);
        if (pend_clear) begin
            fifo_q.delete();
            src_q.delete();
            resp_pend = 0;
        end else begin
            if (pend_pop) void'(fifo_q.pop_front());
            if (pend_b) begin
                resp_pend--;
                resp_idx++;
            end
            if (pend_wlast) resp_pend++;
            if (src_q.size() > 0 && fifo_q.size() < 16 && (prod_gap == 0 || cyc % prod_gap == 0))
                fifo_q.push_back(src_q.pop_front());
        end
        cyc++;
        fifo_empty    = (fifo_q.size() == 0);
        fifo_data_out = fifo_empty ? $urandom : fifo_q[0];
        cmd_ready     = ($urandom_range(99) < cmd_pct);
        wready        = ($urandom_range(99) < w_pct);
        bvalid        = (resp_pend > 0) && ($urandom_range(99) < b_pct);
        berr          = bvalid && berr_plan[resp_idx[2:0]];
        #1;
        pend_clear = rst;
        pend_pop   = !rst && mstr0_ready && !fifo_empty;
        if (pend_pop) pop_cnt++;
        pend_b     = !rst && bvalid && bready;
        pend_wlast = !rst && wvalid && wready && wlast;
    end

    // Monitor: compares every DUT-presented transfer against the scoreboard.
    always begin
        @(negedge clk);
        #2;
        mon_cyc++;
        if (rst) begin
            prev_stall = 0;
            pend_berr  = 0;
        end else begin
            if (start && !busy) start_cyc = mon_cyc;
            if (prev_stall) begin
                chk("cmd_valid_held", cmd_valid, 1);
                chk("cmd_addr_held", cmd_addr, prev_addr);
                chk("cmd_len_held", cmd_len, prev_len);
            end
            if (pend_berr) chk("err_after_berr", err, 1);
            if (cmd_valid) cmdv_cnt++;
            if (cmd_valid && cmd_ready) begin
                if (exp_cmd_q.size() == 0) chk("cmd_extra", 1, 0);
                else begin
                    cmd_t c;
                    c = exp_cmd_q.pop_front();
                    chk("cmd_addr", cmd_addr, c.addr);
                    chk("cmd_len", cmd_len, c.len);
                end
            end
            if (wvalid) chk("wvalid_with_empty", fifo_empty, 0);
            if ((mstr0_ready && !fifo_empty) || (wvalid && wready))
                chk("pop_eq_beat", mstr0_ready && !fifo_empty, wvalid && wready);
            if (wvalid && wready) begin
                beat_cnt++;
                if (exp_beat_q.size() == 0) chk("beat_extra", 1, 0);
                else begin
                    beat_t b;
                    b = exp_beat_q.pop_front();
                    chk("wdata", wdata, b.data);
                    chk("wlast", wlast, b.last);
                end
            end
            pend_berr = bvalid && bready && berr;
            if (done) begin
                done_cnt++;
                done_cyc = mon_cyc;
                chk("busy_at_done", busy, 0);
                if (exp_done_q.size() == 0) chk("done_extra", 1, 0);
                else chk("err_at_done", err, exp_done_q.pop_front());
            end
            prev_stall = cmd_valid && !cmd_ready;
            prev_addr  = cmd_addr;
            prev_len   = cmd_len;
        end
    end

    task automatic outputs_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_mstr0_ready"}, mstr0_ready, 0);
        chk({tag, "_cmd_valid"}, cmd_valid, 0);
        chk({tag, "_wvalid"}, wvalid, 0);
        chk({tag, "_wlast"}, wlast, 0);
        chk({tag, "_bready"}, bready, 0);
        chk({tag, "_cmd_addr"}, cmd_addr, 0);
        chk({tag, "_cmd_len"}, cmd_len, 0);
    endtask

    task automatic pulse_start(input logic [31:0] base, input int unsigned n);
        @(negedge clk);
        start       = 1'b1;
        base_addr   = base;
        total_words = 16'(n);
        @(negedge clk);
        start = 1'b0;
        #3;
        if (n != 0) begin
            chk("busy_after_start", busy, 1);
            chk("err_cleared_on_start", err, 0);
        end
    endtask

    // Reference: split n words into bursts of up to 16 beats at 4 bytes/beat.
    task automatic load_job(input logic [31:0] base, input int unsigned n, input logic [7:0] plan);
        logic [31:0] data[$];
        int unsigned off, len, k;
        logic        e;
        for (int unsigned i = 0; i < n; i++) begin
            data.push_back($urandom);
            src_q.push_back(data[i]);
        end
        off = 0;
        k = 0;
        e = 1'b0;
        while (off < n) begin
            len = (n - off > 16) ? 16 : n - off;
            exp_cmd_q.push_back('{addr: base + 32'(off) * 32'd4, len: 5'(len)});
            for (int unsigned j = 0; j < len; j++)
                exp_beat_q.push_back('{data: data[off + j], last: (j == len - 1)});
            e = e | plan[k];
            k++;
            off += len;
        end
        exp_done_q.push_back(e);
    endtask

    task automatic run_job(input logic [31:0] base, input int unsigned n, input int unsigned gap,
                           input int unsigned cp, input int unsigned wp, input int unsigned bp,
                           input logic [7:0] plan, input bit prefill);
        int unsigned p0, d0, c0, t;
        cmd_pct   = cp;
        w_pct     = wp;
        b_pct     = bp;
        berr_plan = plan;
        resp_idx  = 0;
        prod_gap  = gap;
        load_job(base, n, plan);
        if (prefill) begin
            t = 0;
            while (fifo_q.size() < ((n > 16) ? 16 : n) && t < 200) begin
                @(negedge clk);
                t++;
            end
        end
        p0 = pop_cnt;
        d0 = done_cnt;
        c0 = cmdv_cnt;
        pulse_start(base, n);
        t = 0;
        while (done_cnt == d0 && t < 4000) begin
            @(negedge clk);
            t++;
        end
        if (done_cnt == d0) chk("done_timeout", 0, 1);
        repeat (3) @(negedge clk);
        chk("done_once", done_cnt - d0, 1);
        chk("pop_count", pop_cnt - p0, n);
        chk("cmd_q_drained", exp_cmd_q.size(), 0);
        chk("beat_q_drained", exp_beat_q.size(), 0);
        chk("done_q_drained", exp_done_q.size(), 0);
        if (n == 0) begin
            chk("zero_done_latency", done_cyc - start_cyc, 2);
            chk("zero_no_cmd_valid", cmdv_cnt - c0, 0);
        end
    endtask

    task automatic reset_mid_burst();
        int unsigned b0, t;
        cmd_pct  = 100;
        w_pct    = 100;
        b_pct    = 100;
        prod_gap = 0;
        load_job(32'h0000_7000, 16, 8'h00);
        t = 0;
        while (fifo_q.size() < 16 && t < 200) begin
            @(negedge clk);
            t++;
        end
        b0 = beat_cnt;
        pulse_start(32'h0000_7000, 16);
        t = 0;
        while (beat_cnt - b0 < 6 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("six_beats_before_reset", beat_cnt - b0, 6);
        rst = 1'b1;
        src_q.delete();
        @(negedge clk);
        rst = 1'b0;
        exp_cmd_q.delete();
        exp_beat_q.delete();
        exp_done_q.delete();
        #3;
        outputs_zero("mid_rst");
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #3;
        outputs_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_job(32'h0000_1000, 40, 0, 100, 100, 100, 8'h00, 1);
        run_job(32'h0000_2000, 5, 3, 100, 100, 100, 8'h00, 0);
        run_job(32'h0000_3000, 33, 0, 50, 50, 50, 8'h00, 0);
        run_job(32'h0000_4000, 32, 0, 100, 100, 100, 8'h02, 0);
        run_job(32'h0000_5000, 0, 0, 100, 100, 100, 8'h00, 0);
        reset_mid_burst();
        run_job(32'h0000_6000, 20, 0, 100, 100, 100, 8'h00, 1);
        run_job(32'hFFFF_FFC0, 40, 0, 70, 70, 70, 8'h01, 0);
        for (int i = 0; i < 4; i++) begin
            run_job($urandom & 32'hFFFF_FFFC, $urandom_range(50, 1), $urandom_range(2),
                    $urandom_range(100, 30), $urandom_range(100, 30), $urandom_range(100, 30),
                    8'($urandom), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=%0d required=finish", cyc);
        $fatal(1, "global timeout");
    end

endmodule
